// File: rtl/vector_rotate_pkg.sv
// Default widths and shared types for the vector rotation pipeline.
// Trig values are Q1.FRAC; +2^FRAC represents 1.0.
package vector_rotate_pkg;

    localparam int IN_W_DEF   = 5;
    localparam int TRIG_W_DEF = 9;
    localparam int FRAC_DEF   = 7;
    localparam int OUT_W_DEF  = 6;

    typedef logic signed [IN_W_DEF-1:0]   coord_t;
    typedef logic signed [TRIG_W_DEF-1:0] trig_t;
    typedef logic signed [OUT_W_DEF-1:0]  out_coord_t;

endpackage

// File: rtl/rotate_term.sv
// One rotated axis: y = sat(round((a*ka +/- b*kb) / 2^FRAC)).
// Latency 2 cycles (products, then round/saturate); no backpressure, accepts every cycle.
// Flow: free-running pipeline, no handshake.
module rotate_term
    import vector_rotate_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int TRIG_W = TRIG_W_DEF,
    parameter int FRAC   = FRAC_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter bit SUB    = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [IN_W-1:0]   a,
    input  logic signed [IN_W-1:0]   b,
    input  logic signed [TRIG_W-1:0] ka,
    input  logic signed [TRIG_W-1:0] kb,
    output logic signed [OUT_W-1:0]  y
);

    localparam int P_W = IN_W + TRIG_W;
    localparam int S_W = P_W + 1;
    // One extra bit so the rounding offset can never overflow the sum.
    localparam int R_W = S_W + 1;

    localparam logic signed [R_W-1:0] HALF = R_W'(1) <<< (FRAC - 1);
    localparam logic signed [R_W-1:0] MAXV = R_W'((1 <<< (OUT_W - 1)) - 1);
    localparam logic signed [R_W-1:0] MINV = ~MAXV;

    logic signed [P_W-1:0]   pa_d, pa_q;
    logic signed [P_W-1:0]   pb_d, pb_q;
    logic signed [S_W-1:0]   sum;
    logic signed [R_W-1:0]   rnd;
    logic signed [R_W-1:0]   shf;
    logic signed [OUT_W-1:0] y_d, y_q;

    always_comb begin
        pa_d = P_W'(a) * P_W'(ka);
        pb_d = P_W'(b) * P_W'(kb);
    end

    always_comb begin
        if (SUB) begin
            sum = S_W'(pa_q) - S_W'(pb_q);
        end else begin
            sum = S_W'(pa_q) + S_W'(pb_q);
        end
        rnd = R_W'(sum) + HALF;
        shf = rnd >>> FRAC;
        if (shf > MAXV) begin
            y_d = MAXV[OUT_W-1:0];
        end else if (shf < MINV) begin
            y_d = MINV[OUT_W-1:0];
        end else begin
            y_d = shf[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pa_q <= '0;
            pb_q <= '0;
            y_q  <= '0;
        end else begin
            pa_q <= pa_d;
            pb_q <= pb_d;
            y_q  <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/vector_rotate_pipe.sv
// Counter-clockwise rotation of (ix,iy) by the angle given as Q1.FRAC cos/sin.
// Latency 2 cycles, one sample per cycle; no backpressure (no handshake).
module vector_rotate_pipe
    import vector_rotate_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int TRIG_W = TRIG_W_DEF,
    parameter int FRAC   = FRAC_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [IN_W-1:0]   ix,
    input  logic signed [IN_W-1:0]   iy,
    input  logic signed [TRIG_W-1:0] cos,
    input  logic signed [TRIG_W-1:0] sin,
    output logic signed [OUT_W-1:0]  ox,
    output logic signed [OUT_W-1:0]  oy
);

    // ox = ix*cos - iy*sin
    rotate_term #(
        .IN_W   (IN_W),
        .TRIG_W (TRIG_W),
        .FRAC   (FRAC),
        .OUT_W  (OUT_W),
        .SUB    (1'b1)
    ) u_term_x (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (ix),
        .b     (iy),
        .ka    (cos),
        .kb    (sin),
        .y     (ox)
    );

    // oy = ix*sin + iy*cos
    rotate_term #(
        .IN_W   (IN_W),
        .TRIG_W (TRIG_W),
        .FRAC   (FRAC),
        .OUT_W  (OUT_W),
        .SUB    (1'b0)
    ) u_term_y (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (ix),
        .b     (iy),
        .ka    (sin),
        .kb    (cos),
        .y     (oy)
    );

endmodule

// File: tb/tb_vector_rotate_pipe.sv
// Directed and streaming checks for vector_rotate_pipe at default widths.
module tb_vector_rotate_pipe;
    import vector_rotate_pkg::*;

    logic       clk;
    logic       rst_n;
    coord_t     ix, iy;
    trig_t      cos_i, sin_i;
    out_coord_t ox, oy;

    int total;
    int bad;
    int lut_c[64];
    int lut_s[64];

    vector_rotate_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ix    (ix),
        .iy    (iy),
        .cos   (cos_i),
        .sin   (sin_i),
        .ox    (ox),
        .oy    (oy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Integer reference: round half up, then clamp to the 6-bit signed range.
    function automatic int rot_ref(int a, int b, int ka, int kb, bit sub);
        int s;
        s = sub ? (a * ka - b * kb) : (a * ka + b * kb);
        s = (s + 64) >>> 7;
        if (s > 31)  s = 31;
        if (s < -32) s = -32;
        return s;
    endfunction

    // Called just after a rising edge; applies a sample and returns outputs two edges later.
    task automatic run_vec(input int a, input int b, input int c, input int s,
                           output int rx, output int ry);
        ix    = coord_t'(a);
        iy    = coord_t'(b);
        cos_i = trig_t'(c);
        sin_i = trig_t'(s);
        repeat (2) @(posedge clk);
        #1;
        rx = int'(ox);
        ry = int'(oy);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ix = 5'sd7; iy = -5'sd3; cos_i = 9'sd128; sin_i = 9'sd0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (ox !== 6'sd0) begin bad++; $display("FAIL reset_ox: got %0d want 0", ox); end
        total++;
        if (oy !== 6'sd0) begin bad++; $display("FAIL reset_oy: got %0d want 0", oy); end
    endtask

    task automatic test_release;
        ix = '0; iy = '0; cos_i = '0; sin_i = '0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ix = 5'sd3; iy = -5'sd5; cos_i = 9'sd128; sin_i = 9'sd0;
        @(posedge clk);
        #1;
        total++;
        if (ox !== 6'sd0 || oy !== 6'sd0) begin
            bad++; $display("FAIL release_edge1: got (%0d,%0d) want (0,0)", ox, oy);
        end
        @(posedge clk);
        #1;
        total++;
        if (ox !== 6'sd3 || oy !== -6'sd5) begin
            bad++; $display("FAIL release_edge2: got (%0d,%0d) want (3,-5)", ox, oy);
        end
    endtask

    task automatic test_identity;
        int rx, ry;
        run_vec(3, -5, 128, 0, rx, ry);
        total++;
        if (rx !== 3 || ry !== -5) begin
            bad++; $display("FAIL identity: got (%0d,%0d) want (3,-5)", rx, ry);
        end
    endtask

    task automatic test_rotations;
        int rx, ry;
        run_vec(3, -5, 0, 128, rx, ry);
        total++;
        if (rx !== 5 || ry !== 3) begin
            bad++; $display("FAIL rot90: got (%0d,%0d) want (5,3)", rx, ry);
        end
        run_vec(-16, 15, -128, 0, rx, ry);
        total++;
        if (rx !== 16 || ry !== -15) begin
            bad++; $display("FAIL rot180: got (%0d,%0d) want (16,-15)", rx, ry);
        end
        run_vec(-16, -16, 0, -128, rx, ry);
        total++;
        if (rx !== -16 || ry !== 16) begin
            bad++; $display("FAIL rot270: got (%0d,%0d) want (-16,16)", rx, ry);
        end
    endtask

    task automatic test_rounding;
        int rx, ry;
        run_vec(1, 0, 64, 0, rx, ry);
        total++;
        if (rx !== 1 || ry !== 0) begin
            bad++; $display("FAIL round_half_pos: got (%0d,%0d) want (1,0)", rx, ry);
        end
        run_vec(1, 0, -64, 0, rx, ry);
        total++;
        if (rx !== 0 || ry !== 0) begin
            bad++; $display("FAIL round_half_neg: got (%0d,%0d) want (0,0)", rx, ry);
        end
        run_vec(1, 1, 91, 91, rx, ry);
        total++;
        if (rx !== 0 || ry !== 1) begin
            bad++; $display("FAIL round_45deg: got (%0d,%0d) want (0,1)", rx, ry);
        end
        // -3*64 = -192 -> (-192+64)>>>7 = -1
        run_vec(-3, 0, 64, 0, rx, ry);
        total++;
        if (rx !== -1 || ry !== 0) begin
            bad++; $display("FAIL round_neg_frac: got (%0d,%0d) want (-1,0)", rx, ry);
        end
    endtask

    task automatic test_saturation;
        int rx, ry;
        run_vec(15, 15, 255, 255, rx, ry);
        total++;
        if (rx !== 0 || ry !== 31) begin
            bad++; $display("FAIL sat_pos: got (%0d,%0d) want (0,31)", rx, ry);
        end
        run_vec(-16, 0, -256, 0, rx, ry);
        total++;
        if (rx !== 31 || ry !== 0) begin
            bad++; $display("FAIL sat_extreme_cos: got (%0d,%0d) want (31,0)", rx, ry);
        end
        // ox = 15*255 - (-16)*255 = 7905 -> 62 -> 31; oy = 15*255 - 16*255 = -255 -> -2
        run_vec(15, -16, 255, 255, rx, ry);
        total++;
        if (rx !== 31 || ry !== -2) begin
            bad++; $display("FAIL sat_mixed: got (%0d,%0d) want (31,-2)", rx, ry);
        end
        // ox = -16*255 - 15*255 = -7905 -> -62 -> -32
        run_vec(-16, 15, 255, 255, rx, ry);
        total++;
        if (rx !== -32 || ry !== -2) begin
            bad++; $display("FAIL sat_neg: got (%0d,%0d) want (-32,-2)", rx, ry);
        end
    endtask

    task automatic test_stream;
        int qx[$];
        int qy[$];
        int ex, ey, a, b;
        for (int ang = 0; ang < 64; ang++) begin
            for (int n = 0; n < 256; n++) begin
                @(posedge clk);
                #1;
                if (qx.size() == 2) begin
                    ex = qx.pop_front();
                    ey = qy.pop_front();
                    total++;
                    if (int'(ox) !== ex || int'(oy) !== ey) begin
                        bad++;
                        $display("FAIL stream ang=%0d n=%0d: got (%0d,%0d) want (%0d,%0d)",
                                 ang, n, ox, oy, ex, ey);
                    end
                end
                a = (n % 32) - 16;
                b = ((n / 32) * 4 + (ang % 4)) - 16;
                ix = coord_t'(a); iy = coord_t'(b);
                cos_i = trig_t'(lut_c[ang]); sin_i = trig_t'(lut_s[ang]);
                qx.push_back(rot_ref(a, b, lut_c[ang], lut_s[ang], 1'b1));
                qy.push_back(rot_ref(a, b, lut_s[ang], lut_c[ang], 1'b0));
            end
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            ex = qx.pop_front();
            ey = qy.pop_front();
            total++;
            if (int'(ox) !== ex || int'(oy) !== ey) begin
                bad++; $display("FAIL stream_flush: got (%0d,%0d) want (%0d,%0d)", ox, oy, ex, ey);
            end
        end
    endtask

    task automatic test_mid_reset;
        ix = 5'sd9; iy = 5'sd7; cos_i = 9'sd128; sin_i = 9'sd0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (ox !== 6'sd9 || oy !== 6'sd7) begin
            bad++; $display("FAIL midreset_pre: got (%0d,%0d) want (9,7)", ox, oy);
        end
        ix = -5'sd12;
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (ox !== 6'sd0 || oy !== 6'sd0) begin
            bad++; $display("FAIL midreset_async: got (%0d,%0d) want (0,0)", ox, oy);
        end
        @(posedge clk);
        #1;
        ix = '0; iy = '0; cos_i = '0; sin_i = '0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (ox !== 6'sd0 || oy !== 6'sd0) begin
            bad++; $display("FAIL midreset_discard1: got (%0d,%0d) want (0,0)", ox, oy);
        end
        @(posedge clk);
        #1;
        total++;
        if (ox !== 6'sd0 || oy !== 6'sd0) begin
            bad++; $display("FAIL midreset_discard2: got (%0d,%0d) want (0,0)", ox, oy);
        end
    endtask

    initial begin
        real th, cr, sr;
        total = 0;
        bad   = 0;
        for (int k = 0; k < 64; k++) begin
            th = 6.283185307179586 * k / 64.0;
            cr = 128.0 * $cos(th);
            sr = 128.0 * $sin(th);
            lut_c[k] = $rtoi(cr >= 0.0 ? cr + 0.5 : cr - 0.5);
            lut_s[k] = $rtoi(sr >= 0.0 ? sr + 0.5 : sr - 0.5);
        end
        test_reset();
        test_release();
        test_identity();
        test_rotations();
        test_rounding();
        test_saturation();
        test_stream();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
